// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the execute stage: ALU control codes, MDU op codes,
// MDU FSM state encoding and small operand helpers.
package mdu_ctrl_pkg;

    // ALU control codes used by the execute-stage ALU decoder
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7
    } alu_ctrl_e;

    // Multiply/divide unit op codes; values 6 and 7 are no-ops
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    // MDU controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Iteration kind selected for the step datapath
    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // Magnitude of a 32-bit value, treating it as two's complement when is_signed
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, input busy, done, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl_step.sv
// mdu_step: one radix-2 iteration on unsigned magnitudes.
//   STEP_MUL: shift-add, multiplier consumed from the LSB of part_lo,
//             product bits shifted into part_lo from the top.
//   STEP_DIV: shift-restoring-subtract, dividend consumed from the MSB of
//             part_lo, quotient bits shifted in at the bottom.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_step
    import mdu_ctrl_pkg::*;
(
    input  logic [31:0] part_hi,
    input  logic [31:0] part_lo,
    input  logic [31:0] operand,
    input  step_mode_e  mode,
    output logic [31:0] nxt_hi,
    output logic [31:0] nxt_lo
);

    logic [32:0] mul_acc;
`ifdef MDU_DIV_EN
    logic [33:0] div_shift;
    logic [33:0] div_diff;
`else
    logic        unused_mode;
    assign unused_mode = mode;
`endif

    // Combinational iteration: conditional add for multiply, trial subtract for divide
    always_comb begin : step_calc
        mul_acc = part_lo[0] ? ({1'b0, part_hi} + {1'b0, operand}) : {1'b0, part_hi};
        nxt_hi  = mul_acc[32:1];
        nxt_lo  = {mul_acc[0], part_lo[31:1]};
`ifdef MDU_DIV_EN
        div_shift = {1'b0, part_hi, part_lo[31]};
        div_diff  = div_shift - {2'b00, operand};
        if (mode == STEP_DIV) begin
            if (!div_diff[33]) begin
                nxt_hi = div_diff[31:0];
                nxt_lo = {part_lo[30:0], 1'b1};
            end else begin
                nxt_hi = div_shift[31:0];
                nxt_lo = {part_lo[30:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit with HI/LO result registers.
// Build option: define MDU_DIV_EN to include DIV/DIVU; without it those ops
// are ignored and no divide datapath is built.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo directly
// RUN   | one step per cycle on operand magnitudes, counter counts down
// FIX   | sign fix-up; hi/lo written at the closing edge, done follows
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int N_ITER = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam int            CW       = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(N_ITER - 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        in_is_mul, in_is_div, accept;
    logic        q_is_mul, q_signed;
    step_mode_e  step_mode;
    logic [31:0] step_opnd, step_hi, step_lo;
    logic [63:0] prod_raw;
    logic [31:0] fix_hi, fix_lo;
    logic        fix_wr;

    assign in_is_mul = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
    assign q_is_mul  = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
    assign q_signed  = (op_q == MDU_MULT) || (op_q == MDU_DIV);
    assign prod_raw  = {phi_q, plo_q};

`ifdef MDU_DIV_EN
    assign in_is_div = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
    assign step_mode = q_is_mul ? STEP_MUL : STEP_DIV;
    assign step_opnd = q_is_mul ? mag32(a_q, q_signed) : mag32(b_q, q_signed);
`else
    logic unused_b_low;
    // Only the sign of B is needed after acceptance when divide is absent
    assign unused_b_low = ^b_q[30:0];
    assign in_is_div = 1'b0;
    assign step_mode = STEP_MUL;
    assign step_opnd = mag32(a_q, q_signed);
`endif

    assign accept = (state_q == ST_IDLE) && bus.start && (in_is_mul || in_is_div);

    mdu_step u_step (
        .part_hi (phi_q),
        .part_lo (plo_q),
        .operand (step_opnd),
        .mode    (step_mode),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)        state_d = ST_RUN;
            ST_RUN:  if (cnt_q == '0)   state_d = ST_FIX;
            ST_FIX:                     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: busy covers RUN and FIX
    always_comb begin : fsm_out
        bus.busy = (state_q != ST_IDLE);
    end

    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Sign fix-up of the magnitude result; a zero divisor suppresses the write
    always_comb begin : fix_calc
        fix_wr = 1'b1;
        fix_hi = prod_raw[63:32];
        fix_lo = prod_raw[31:0];
        if ((op_q == MDU_MULT) && (a_q[31] ^ b_q[31])) begin
            {fix_hi, fix_lo} = -prod_raw;
        end
`ifdef MDU_DIV_EN
        if (!q_is_mul) begin
            fix_wr = (b_q != '0);
            fix_lo = ((op_q == MDU_DIV) && (a_q[31] ^ b_q[31])) ? -plo_q : plo_q;
            fix_hi = ((op_q == MDU_DIV) && a_q[31]) ? -phi_q : phi_q;
        end
`endif
    end

    // Datapath next values: operand latch, iteration, result write
    always_comb begin : dp_next
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = bus.op;
                    a_d   = bus.A;
                    b_d   = bus.B;
                    cnt_d = CNT_LOAD;
                    phi_d = '0;
`ifdef MDU_DIV_EN
                    plo_d = in_is_mul ? mag32(bus.B, bus.op == MDU_MULT)
                                      : mag32(bus.A, bus.op == MDU_DIV);
`else
                    plo_d = mag32(bus.B, bus.op == MDU_MULT);
`endif
                end else if (bus.start && (bus.op == MDU_MTHI)) begin
                    hi_d = bus.A;
                end else if (bus.start && (bus.op == MDU_MTLO)) begin
                    lo_d = bus.A;
                end
            end
            ST_RUN: begin
                phi_d = step_hi;
                plo_d = step_lo;
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            ST_FIX: begin
                done_d = 1'b1;
                if (fix_wr) begin
                    hi_d = fix_hi;
                    lo_d = fix_lo;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            phi_q  <= '0;
            plo_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed cases plus randomized ops against an
// arithmetic reference model of HI/LO. Honours MDU_DIV_EN like the design.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int N_ITER = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_ctrl_if bus_if ();

    mdu_ctrl #(.N_ITER(N_ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_is_iter(input logic [2:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return 1'b1;
            MDU_DIV, MDU_DIVU:   return DIV_EN;
            default:             return 1'b0;
        endcase
    endfunction

    // Expected {hi,lo} after op, from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        logic [63:0] r;
        longint sa, sb;
        int      sa32, sb32, q, rm;
        r = {hi, lo};
        case (op)
            MDU_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end
            MDU_MULTU: r = {32'h0, a} * {32'h0, b};
            MDU_DIV: if (DIV_EN && b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    sa32 = a;
                    sb32 = b;
                    q    = sa32 / sb32;
                    rm   = sa32 % sb32;
                    r    = {rm, q};
                end
            end
            MDU_DIVU: if (DIV_EN && b != 0) r = {a % b, a / b};
            MDU_MTHI: r = {a, lo};
            MDU_MTLO: r = {hi, a};
            default: ;
        endcase
        return r;
    endfunction

    // Issue one op from IDLE, optionally scrambling inputs while busy
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, input string tag);
        logic [63:0] exp;
        int          cyc;
        bit          hold_ok;
        exp = ref_result(op, a, b, m_hi, m_lo);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.A     = a;
        bus_if.B     = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        if (ref_is_iter(op)) begin
            cyc     = 0;
            hold_ok = 1'b1;
            while (bus_if.busy === 1'b1 && cyc < 4 * N_ITER) begin
                cyc++;
                if (bus_if.done !== 1'b0 || bus_if.hi !== m_hi || bus_if.lo !== m_lo) hold_ok = 1'b0;
                if (junk) begin
                    bus_if.start = 1'($urandom_range(0, 1));
                    bus_if.op    = 3'($urandom_range(0, 7));
                    bus_if.A     = $urandom;
                    bus_if.B     = $urandom;
                end
                @(negedge clk);
            end
            bus_if.start = 1'b0;
            check({tag, ":busy_cycles"}, 64'(cyc), 64'(N_ITER + 1));
            check({tag, ":hold"}, 64'(hold_ok), 64'd1);
            check({tag, ":done"}, 64'(bus_if.done), 64'd1);
        end else begin
            check({tag, ":busy"}, 64'(bus_if.busy), 64'd0);
            check({tag, ":done"}, 64'(bus_if.done), 64'd0);
        end
        check({tag, ":hilo"}, {bus_if.hi, bus_if.lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(negedge clk);
        check({tag, ":after"}, {62'd0, bus_if.busy, bus_if.done}, 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        int          cyc;
        bit          quiet;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        reset        = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = '0;
        bus_if.A     = '0;
        bus_if.B     = '0;
        @(negedge clk);
        check("reset_state", {29'd0, bus_if.busy, bus_if.done, 1'b0, bus_if.hi ^ bus_if.lo}, 64'd0);
        check("reset_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        check("multu_max_lit", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, "mult_neg");
        check("mult_neg_lit", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`ifdef MDU_DIV_EN
        do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        check("div_neg_lit", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_lit", {bus_if.hi, bus_if.lo}, 64'h0000_0000_8000_0000);
`endif
        do_op(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0, "mthi");
        do_op(MDU_DIVU, 32'd5, 32'd0, 1'b0, "divu_zero");
        check("divu_zero_hi", 64'(bus_if.hi), 64'h1234_5678);
`ifndef MDU_DIV_EN
        do_op(MDU_DIV, 32'd9, 32'd3, 1'b0, "div_off");
`endif

        // MTLO while busy must be dropped, not queued
        exp = ref_result(MDU_MULTU, 32'h0001_2345, 32'h0000_BEEF, m_hi, m_lo);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = MDU_MULTU;
        bus_if.A     = 32'h0001_2345;
        bus_if.B     = 32'h0000_BEEF;
        @(negedge clk);
        cyc = 0;
        while (bus_if.busy === 1'b1 && cyc < 4 * N_ITER) begin
            cyc++;
            if (cyc == 3) begin
                bus_if.start = 1'b1;
                bus_if.op    = MDU_MTLO;
                bus_if.A     = 32'h0000_AAAA;
            end else begin
                bus_if.start = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.start = 1'b0;
        check("mtlo_busy:cycles", 64'(cyc), 64'(N_ITER + 1));
        check("mtlo_busy:done", 64'(bus_if.done), 64'd1);
        check("mtlo_busy:hilo", {bus_if.hi, bus_if.lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        repeat (3) @(negedge clk);
        check("mtlo_busy:not_queued", {bus_if.hi, bus_if.lo}, exp);

        // Reset in the middle of a multiply aborts it
        bus_if.start = 1'b1;
        bus_if.op    = MDU_MULTU;
        bus_if.A     = 32'hDEAD_BEEF;
        bus_if.B     = 32'h0000_0123;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("abort:busy_before", 64'(bus_if.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort:outputs", {30'd0, bus_if.busy, bus_if.done, bus_if.hi | bus_if.lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (2 * N_ITER) begin
            @(negedge clk);
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.hi !== 32'd0 || bus_if.lo !== 32'd0)
                quiet = 1'b0;
        end
        check("abort:no_late_result", 64'(quiet), 64'd1);

        // Randomized ops with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFF_FFFF;
                2: r_a = 32'h8000_0000;
                3: r_b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, r_op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have a parameter N_ITER, default 32: the number of radix-2 iteration cycles per multiply or divide.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: the op request, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits: MULT, MULTU, DIV, DIVU, MTHI or MTLO; any other value is a no-op.
REQ-006 The block SHALL have port A, input, 32 bits: the multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The block SHALL have port B, input, 32 bits: the multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiply or divide is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have port hi, output, 32 bits: the HI register (product high word, or remainder).
REQ-011 The block SHALL have port lo, output, 32 bits: the LO register (product low word, or quotient).

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and FIX, and SHALL hold an iteration counter of width clog2(N_ITER).
REQ-013 In IDLE, start with MULT/MULTU/DIV/DIVU SHALL latch A, B and op, load the counter with N_ITER-1, and go to RUN at the next edge.
REQ-014 In RUN, each cycle SHALL perform one shift-add (multiply) or one shift-restoring-subtract (divide) on the unsigned magnitudes.
REQ-015 In RUN, each cycle SHALL decrement the counter; when the counter is 0, the FSM SHALL go to FIX.
REQ-016 In FIX, the block SHALL apply the sign fix-up for signed ops, write hi/lo at the closing edge, and return to IDLE.
REQ-017 busy SHALL be high in RUN and FIX only: N_ITER+1 cycles, beginning the cycle after start is accepted.
REQ-018 done SHALL pulse high for exactly the first IDLE cycle after FIX, the same cycle in which new hi/lo are first visible.
REQ-019 hi/lo SHALL hold their previous values throughout RUN and FIX.
REQ-020 MTHI/MTLO with start in IDLE SHALL write A to hi/lo at the next edge, with no busy and no done.
REQ-021 start with any op SHALL be ignored while busy=1 and SHALL NOT be queued.
REQ-022 MULT SHALL produce a signed 64-bit product {hi,lo}; MULTU SHALL produce an unsigned 64-bit product {hi,lo}.
REQ-023 DIV SHALL produce lo = quotient truncated toward zero, and hi = remainder with the sign of the dividend.
REQ-024 DIVU SHALL produce the unsigned quotient in lo and the unsigned remainder in hi.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0x00000000.
REQ-026 A divide with B=0 SHALL run the full N_ITER+1 busy cycles and pulse done, leaving hi/lo unchanged.
REQ-027 A change of A, B or op after acceptance SHALL NOT affect the result of the op in progress.

Reset
REQ-028 reset SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and the latched operands to 0.
REQ-029 Reset mid-operation SHALL abort the op; the aborted op SHALL NOT later produce a done pulse or any hi/lo write.

Configuration
REQ-030 With macro MDU_DIV_EN defined, DIV/DIVU SHALL behave as specified above.
REQ-031 Without MDU_DIV_EN, DIV/DIVU SHALL be no-ops (no busy, no done, hi/lo unchanged), and no divide datapath logic SHALL be synthesized.

Structure
REQ-032 The op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO) and the FSM state encodings SHALL live in the shared constants header beside the ALU control codes.
REQ-033 One combinational iteration datapath SHALL be split out as sub-module mdu_step (inputs: partial hi/lo, operand, mode; outputs: next partial hi/lo); mdu_ctrl SHALL hold the FSM, counter, operand latches and sign fix-up.

Verification
REQ-034 The bench SHALL check: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> busy 33 cycles, done pulse, hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 The bench SHALL check: MULT A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 The bench SHALL check: DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; also DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 The bench SHALL check: after MTHI 0x12345678, DIVU A=5, B=0 -> 33 busy cycles, done pulse, hi=0x12345678, lo unchanged.
REQ-038 The bench SHALL check: start MULTU, then MTLO 0xAAAA at busy cycle 3 -> ignored, lo=product; reset at busy cycle 10 -> busy=0, hi=lo=0 at once, no done.
REQ-039 The bench SHALL check: built without MDU_DIV_EN, DIV A=9, B=3 -> busy stays 0, no done, hi/lo unchanged.
